frame_read_arbiter: RTL and testbench
=====================================

# frame_read_arbiter

Shares the single read port of the QVGA frame buffer between VGA scan-out and one auxiliary requester, such as a colour-statistics or snapshot engine. VGA scan-out has absolute priority. The auxiliary requester is granted reads only inside display blanking, with a per-window burst budget and a starvation flag. The block sits between the QVGA memory controller, the aux engine and the frame buffer read side, all on one system clock.

## Interface
Parameters:
- ADDR_W, 17, frame buffer address width (320x240 words)
- DATA_W, 16, RGB565 pixel width
- RD_LAT, 1, frame buffer read latency in cycles (address registered at k, data valid at k+RD_LAT); legal 1..4
- AUX_BURST, 64, maximum aux grants per blanking window
- STARVE_LIM, 4096, cycles an aux request may wait before aux_starved is raised

Ports:
- clk  in  1  system clock; one clock for the whole block
- reset  in  1  asynchronous, active-high reset
- blank  in  1  high while the display is outside the active area (DE low)
- vga_req  in  1  scan-out read request, one per cycle
- vga_addr  in  ADDR_W  scan-out read address
- vga_valid  out  1  scan-out read data valid
- vga_data  out  DATA_W  scan-out read data
- aux_req  in  1  aux read request; held with aux_addr stable until granted
- aux_addr  in  ADDR_W  aux read address
- aux_gnt  out  1  aux request accepted this cycle (combinational)
- aux_valid  out  1  aux read data valid
- aux_data  out  DATA_W  aux read data
- aux_starved  out  1  aux request pending for at least STARVE_LIM cycles
- mem_oe  out  1  frame buffer read enable
- mem_addr  out  ADDR_W  frame buffer read address
- mem_rdata  in  DATA_W  frame buffer read data

## Operation
Window FSM, states WAIT_BLANK, AUX_OPEN and AUX_CLOSED; reset state is WAIT_BLANK:
- WAIT_BLANK -> AUX_OPEN on blank=1; aux_cnt cleared on entry.
- AUX_OPEN -> AUX_CLOSED when aux_cnt reaches AUX_BURST.
- AUX_OPEN -> WAIT_BLANK on blank=0.
- AUX_CLOSED -> WAIT_BLANK on blank=0.

Grant rules:
- aux_gnt = aux_req & ~vga_req & (state==AUX_OPEN) & (aux_cnt<AUX_BURST).
- A vga_req is always issued.
- When vga_req and aux_req are both high in AUX_OPEN, VGA wins. The aux request stays pending and aux_cnt does not increment.
- aux_cnt increments on each aux_gnt. It saturates at AUX_BURST.

Issue stage (registered):
- mem_oe = vga_req | aux_gnt.
- mem_addr = vga_addr if vga_req, aux_addr if aux_gnt, otherwise it holds its previous value.
- The issued tag (NONE/VGA/AUX) enters an RD_LAT-deep tag pipe.

Return stage (registered):
- When the tag emerging from the pipe is VGA, capture mem_rdata into vga_data and pulse vga_valid.
- When the tag is AUX, capture into aux_data and pulse aux_valid.
- Data registers hold their value when valid is low.

Starvation counter:
- Counts cycles while aux_req=1 and aux_gnt=0. It clears on aux_gnt or aux_req=0 and saturates at STARVE_LIM.
- aux_starved = (counter==STARVE_LIM).

Boundary behaviour:
- blank falling while an aux read is in flight: that read still completes and returns on aux_valid.
- vga_valid and aux_valid are never high in the same cycle.
- Reset mid-operation: tag pipe flushed to NONE, so no valid pulses occur for reads issued before reset.

## Timing
- All outputs reset to 0, except aux_gnt, which is combinational and is 0 while in reset because the FSM is in WAIT_BLANK.
- Request sampled at cycle N; mem_oe/mem_addr at N+1; mem_rdata at N+1+RD_LAT; vga_valid/aux_valid at N+2+RD_LAT. With RD_LAT=1 the latency is 3 cycles.
- Read order is preserved: returns follow issue order exactly.
- Throughput: one read per cycle. Back-to-back VGA requests are sustained indefinitely.
- blank to AUX_OPEN: one cycle, so the first possible aux_gnt is the cycle after blank is sampled high.

## Structure
- Package frame_arb_pkg holds:
  - enum arb_state_t {WAIT_BLANK, AUX_OPEN, AUX_CLOSED}
  - enum rd_tag_t {TAG_NONE, TAG_VGA, TAG_AUX}
  - default ADDR_W and DATA_W localparams shared with frame_buffer and QVGA_MemController
- Sub-module rd_tag_pipe: RD_LAT-stage shift register of rd_tag_t with asynchronous reset to TAG_NONE.
- Top file: FSM, grant logic, issue and return registers, starvation counter.

## Test plan
- VGA only, blank=0, vga_req every cycle with addresses 0..319 and memory model word=addr:
  - 320 vga_valid pulses with vga_data 0..319, each 3 cycles after its request (RD_LAT=1).
  - aux_gnt stays 0 throughout.
- aux_req held with aux_addr=0x1000 during blank=0 for 10 cycles, then blank=1:
  - aux_gnt pulses exactly one cycle after blank is sampled high.
  - aux_data=0x1000 with aux_valid 3 cycles later.
- blank=1 for 200 cycles, aux_req continuously high, AUX_BURST=64:
  - exactly 64 aux_gnt pulses, then the FSM holds AUX_CLOSED until blank falls.
  - a second window grants again.
- VGA and aux requesting together in AUX_OPEN on alternating cycles:
  - VGA is never delayed.
  - aux is granted only in VGA-free cycles.
  - vga_valid and aux_valid never overlap.
- aux_req held for STARVE_LIM cycles with blank=0 (STARVE_LIM=16 in test):
  - aux_starved rises at cycle 16 and clears the cycle after the first aux_gnt.
- reset asserted one cycle after an aux grant is issued:
  - no aux_valid appears.
  - all outputs are 0 during reset; the FSM restarts in WAIT_BLANK.

Source files
------------

// File: rtl/frame_read_arbiter_pkg.sv
// frame_arb_pkg: shared types and default widths for the frame buffer read path.
//   arb_state_t : blanking-window FSM states of frame_read_arbiter
//   rd_tag_t    : owner tag of an issued frame buffer read
//   FB_ADDR_W / FB_DATA_W : default widths shared with frame_buffer and
//                           QVGA_MemController (320x240 words of RGB565)
package frame_arb_pkg;

  localparam int FB_ADDR_W = 17;
  localparam int FB_DATA_W = 16;

  typedef enum logic [1:0] {
    WAIT_BLANK = 2'd0,
    AUX_OPEN   = 2'd1,
    AUX_CLOSED = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_VGA  = 2'd1,
    TAG_AUX  = 2'd2
  } rd_tag_t;

endpackage

// File: rtl/frame_read_arbiter_if.sv
// frame_read_arbiter_if: all request, return and frame buffer signals of the
// read arbiter bundled in one interface.
//   slave  : arbiter view (takes requests and mem_rdata, drives grants/returns/mem)
//   master : environment view (VGA scan-out, aux engine, frame buffer model)
interface frame_read_arbiter_if
  import frame_arb_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DATA_W = FB_DATA_W
);

  logic              blank;
  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_valid;
  logic [DATA_W-1:0] vga_data;
  logic              aux_req;
  logic [ADDR_W-1:0] aux_addr;
  logic              aux_gnt;
  logic              aux_valid;
  logic [DATA_W-1:0] aux_data;
  logic              aux_starved;
  logic              mem_oe;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  blank, vga_req, vga_addr, aux_req, aux_addr, mem_rdata,
    output vga_valid, vga_data, aux_gnt, aux_valid, aux_data, aux_starved,
           mem_oe, mem_addr
  );

  modport master (
    output blank, vga_req, vga_addr, aux_req, aux_addr, mem_rdata,
    input  vga_valid, vga_data, aux_gnt, aux_valid, aux_data, aux_starved,
           mem_oe, mem_addr
  );

endinterface

// File: rtl/frame_read_arbiter_rd_tag_pipe.sv
// rd_tag_pipe: DEPTH-stage shift register of read owner tags, aligning each
// issued read's tag with its data coming back from the frame buffer.
//   clk, reset : system clock, async active-high reset (flushes to TAG_NONE)
//   tag_i      : tag of the read issued this cycle
//   tag_o      : tag of the read whose data is on mem_rdata this cycle
module rd_tag_pipe
  import frame_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic    clk,
  input  logic    reset,
  input  rd_tag_t tag_i,
  output rd_tag_t tag_o
);

  rd_tag_t stage_q [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= TAG_NONE;
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/frame_read_arbiter.sv
// frame_read_arbiter: shares the frame buffer read port between VGA scan-out
// (absolute priority) and one aux requester that is served only during
// blanking, with a per-window grant budget and a starvation flag.
//   clk, reset : system clock, async active-high reset
//   bus        : frame_read_arbiter_if.slave (requests, returns, memory port)
//
// state      | meaning
// WAIT_BLANK | active video, no aux grants, burst count held at zero
// AUX_OPEN   | blanking, aux may be granted while budget remains
// AUX_CLOSED | blanking, budget used up, wait for next active line
module frame_read_arbiter
  import frame_arb_pkg::*;
#(
  parameter int ADDR_W     = FB_ADDR_W,
  parameter int DATA_W     = FB_DATA_W,
  parameter int RD_LAT     = 1,
  parameter int AUX_BURST  = 64,
  parameter int STARVE_LIM = 4096
) (
  input logic clk,
  input logic reset,
  frame_read_arbiter_if.slave bus
);

  localparam int BCNT_W = $clog2(AUX_BURST + 1);
  localparam int SCNT_W = $clog2(STARVE_LIM + 1);
  localparam logic [BCNT_W-1:0] BURST_MAX  = BCNT_W'(AUX_BURST);
  localparam logic [SCNT_W-1:0] STARVE_MAX = SCNT_W'(STARVE_LIM);

  arb_state_t        state_q, state_d;
  logic [BCNT_W-1:0] aux_cnt_q, aux_cnt_d;
  logic [SCNT_W-1:0] starve_q, starve_d;
  logic              aux_gnt;

  logic              mem_oe_q, mem_oe_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  rd_tag_t           issue_tag_q, issue_tag_d;
  rd_tag_t           ret_tag;

  logic              vga_valid_q, vga_valid_d;
  logic [DATA_W-1:0] vga_data_q, vga_data_d;
  logic              aux_valid_q, aux_valid_d;
  logic [DATA_W-1:0] aux_data_q, aux_data_d;

  // Window FSM and grant
  always_comb begin
    state_d   = state_q;
    aux_cnt_d = aux_cnt_q;
    aux_gnt   = bus.aux_req & ~bus.vga_req & (state_q == AUX_OPEN) &
                (aux_cnt_q < BURST_MAX);
    case (state_q)
      WAIT_BLANK: begin
        aux_cnt_d = '0;
        if (bus.blank) state_d = AUX_OPEN;
      end
      AUX_OPEN: begin
        // grant is gated by aux_cnt < BURST_MAX, so the count saturates
        if (aux_gnt) aux_cnt_d = aux_cnt_q + BCNT_W'(1);
        if (!bus.blank)                  state_d = WAIT_BLANK;
        else if (aux_cnt_q == BURST_MAX) state_d = AUX_CLOSED;
      end
      AUX_CLOSED: begin
        if (!bus.blank) state_d = WAIT_BLANK;
      end
      default: state_d = WAIT_BLANK;
    endcase
  end

  // Issue stage
  always_comb begin
    mem_oe_d    = bus.vga_req | aux_gnt;
    mem_addr_d  = mem_addr_q;
    issue_tag_d = TAG_NONE;
    if (bus.vga_req) begin
      mem_addr_d  = bus.vga_addr;
      issue_tag_d = TAG_VGA;
    end else if (aux_gnt) begin
      mem_addr_d  = bus.aux_addr;
      issue_tag_d = TAG_AUX;
    end
  end

  // Tag leaves the pipe in the same cycle its data is on mem_rdata
  rd_tag_pipe #(.DEPTH(RD_LAT)) u_tag_pipe (
    .clk   (clk),
    .reset (reset),
    .tag_i (issue_tag_q),
    .tag_o (ret_tag)
  );

  // Return stage
  always_comb begin
    vga_valid_d = (ret_tag == TAG_VGA);
    aux_valid_d = (ret_tag == TAG_AUX);
    vga_data_d  = vga_valid_d ? bus.mem_rdata : vga_data_q;
    aux_data_d  = aux_valid_d ? bus.mem_rdata : aux_data_q;
  end

  // Starvation counter
  always_comb begin
    starve_d = starve_q;
    if (!bus.aux_req || aux_gnt) starve_d = '0;
    else if (starve_q != STARVE_MAX) starve_d = starve_q + SCNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= WAIT_BLANK;
      aux_cnt_q   <= '0;
      starve_q    <= '0;
      mem_oe_q    <= 1'b0;
      mem_addr_q  <= '0;
      issue_tag_q <= TAG_NONE;
      vga_valid_q <= 1'b0;
      vga_data_q  <= '0;
      aux_valid_q <= 1'b0;
      aux_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      aux_cnt_q   <= aux_cnt_d;
      starve_q    <= starve_d;
      mem_oe_q    <= mem_oe_d;
      mem_addr_q  <= mem_addr_d;
      issue_tag_q <= issue_tag_d;
      vga_valid_q <= vga_valid_d;
      vga_data_q  <= vga_data_d;
      aux_valid_q <= aux_valid_d;
      aux_data_q  <= aux_data_d;
    end
  end

  assign bus.aux_gnt     = aux_gnt;
  assign bus.aux_starved = (starve_q == STARVE_MAX);
  assign bus.mem_oe      = mem_oe_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.vga_valid   = vga_valid_q;
  assign bus.vga_data    = vga_data_q;
  assign bus.aux_valid   = aux_valid_q;
  assign bus.aux_data    = aux_data_q;

endmodule

// File: tb/tb_frame_read_arbiter.sv
// Self-checking bench for frame_read_arbiter (RD_LAT=1, AUX_BURST=64,
// STARVE_LIM=16). Inputs are driven just after the falling edge and outputs
// are sampled 1 ns later, so registered outputs show the last rising edge.
module tb_frame_read_arbiter;
  import frame_arb_pkg::*;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  frame_read_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  frame_read_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(1),
    .AUX_BURST(64), .STARVE_LIM(16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Frame buffer model: word = low bits of address, one cycle latency
  always @(posedge clk) if (bus.mem_oe) bus.mem_rdata <= bus.mem_addr[DATA_W-1:0];

  typedef struct {
    logic              b, vr;
    logic [ADDR_W-1:0] va;
    logic              ar;
    logic [ADDR_W-1:0] aa;
    logic              g, oe;
    logic [ADDR_W-1:0] ma;
    logic              vv;
    logic [DATA_W-1:0] vd;
    logic              av;
    logic [DATA_W-1:0] ad;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic b, input logic vr, input logic [ADDR_W-1:0] va,
                     input logic ar, input logic [ADDR_W-1:0] aa);
    @(negedge clk);
    bus.blank    = b;
    bus.vga_req  = vr;
    bus.vga_addr = va;
    bus.aux_req  = ar;
    bus.aux_addr = aa;
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".aux_gnt"},     32'(bus.aux_gnt), 0);
    chk({tag, ".vga_valid"},   32'(bus.vga_valid), 0);
    chk({tag, ".vga_data"},    32'(bus.vga_data), 0);
    chk({tag, ".aux_valid"},   32'(bus.aux_valid), 0);
    chk({tag, ".aux_data"},    32'(bus.aux_data), 0);
    chk({tag, ".aux_starved"}, 32'(bus.aux_starved), 0);
    chk({tag, ".mem_oe"},      32'(bus.mem_oe), 0);
    chk({tag, ".mem_addr"},    32'(bus.mem_addr), 0);
    chk({tag, ".state"},       32'(dut.state_q), 32'(WAIT_BLANK));
  endtask

  initial begin
    logic [ADDR_W-1:0] next_a;
    int gnt_cnt;

    //            b  vr va     ar aa        g  oe ma     vv vd      av ad
    tbl[0]  = '{1, 0, 0,     0, 0,       0, 0, 0,     0, 0,      0, 0};
    tbl[1]  = '{1, 1, 'h10,  1, 'h3000,  0, 0, 0,     0, 0,      0, 0};
    tbl[2]  = '{1, 0, 0,     1, 'h3000,  1, 1, 'h10,  0, 0,      0, 0};
    tbl[3]  = '{1, 1, 'h11,  0, 0,       0, 1, 'h3000,0, 0,      0, 0};
    tbl[4]  = '{1, 0, 0,     1, 'h3001,  1, 1, 'h11,  1, 'h10,   0, 0};
    tbl[5]  = '{1, 1, 'h12,  1, 'h3002,  0, 1, 'h3001,0, 'h10,   1, 'h3000};
    tbl[6]  = '{1, 0, 0,     1, 'h3002,  1, 1, 'h12,  1, 'h11,   0, 'h3000};
    tbl[7]  = '{1, 1, 'h13,  0, 0,       0, 1, 'h3002,0, 'h11,   1, 'h3001};
    tbl[8]  = '{0, 0, 0,     0, 0,       0, 1, 'h13,  1, 'h12,   0, 'h3001};
    tbl[9]  = '{0, 0, 0,     0, 0,       0, 0, 'h13,  0, 'h12,   1, 'h3002};
    tbl[10] = '{0, 0, 0,     0, 0,       0, 0, 'h13,  1, 'h13,   0, 'h3002};
    tbl[11] = '{0, 0, 0,     0, 0,       0, 0, 'h13,  0, 'h13,   0, 'h3002};

    bus.blank = 0; bus.vga_req = 0; bus.vga_addr = '0;
    bus.aux_req = 0; bus.aux_addr = '0;

    // Reset values
    repeat (2) @(negedge clk);
    #1 chk_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    // VGA only: 320 back-to-back reads, aux held but never granted
    for (int c = 0; c < 325; c++) begin
      cyc(0, c < 320, 17'(c), c < 320, 17'h0ABC);
      chk("vga.aux_gnt", 32'(bus.aux_gnt), 0);
      chk("vga.aux_valid", 32'(bus.aux_valid), 0);
      chk("vga.valid", 32'(bus.vga_valid), 32'(c >= 3 && c <= 322));
      if (c >= 3 && c <= 322) chk("vga.data", 32'(bus.vga_data), 32'(c - 3));
    end

    // Aux held during active video, then blank rises
    for (int c = 0; c < 16; c++) begin
      cyc(c >= 10, 0, 0, c <= 11, 17'h1000);
      chk("first.aux_gnt", 32'(bus.aux_gnt), 32'(c == 11));
      chk("first.aux_valid", 32'(bus.aux_valid), 32'(c == 14));
      if (c == 14) chk("first.aux_data", 32'(bus.aux_data), 32'h1000);
    end
    repeat (3) cyc(0, 0, 0, 0, 0);

    // Burst budget over a long blanking window
    next_a = 17'h2000;
    gnt_cnt = 0;
    for (int c = 0; c < 200; c++) begin
      cyc(1, 0, 0, 1, next_a);
      chk("burst.aux_gnt", 32'(bus.aux_gnt), 32'(c >= 1 && c <= 64));
      chk("burst.aux_valid", 32'(bus.aux_valid), 32'(c >= 4 && c <= 67));
      if (c >= 4 && c <= 67) chk("burst.aux_data", 32'(bus.aux_data), 32'h2000 + 32'(c - 4));
      chk("burst.aux_starved", 32'(bus.aux_starved), 32'(c >= 81));
      if (bus.aux_gnt) begin
        gnt_cnt++;
        next_a = next_a + 17'd1;
      end
    end
    chk("burst.gnt_count", 32'(gnt_cnt), 64);
    chk("burst.state", 32'(dut.state_q), 32'(AUX_CLOSED));

    // Second window grants again
    for (int c = 0; c < 4; c++) begin
      cyc(c >= 2, 0, 0, 1, next_a);
      chk("win2.aux_gnt", 32'(bus.aux_gnt), 32'(c == 3));
    end
    cyc(0, 0, 0, 0, 0);
    chk("win2.starved_clr", 32'(bus.aux_starved), 0);
    repeat (6) cyc(0, 0, 0, 0, 0);

    // Starvation flag
    for (int c = 0; c < 24; c++) begin
      cyc(c >= 20, 0, 0, c <= 21, 17'h5000);
      chk("starve.flag", 32'(bus.aux_starved), 32'(c >= 16 && c <= 21));
      chk("starve.aux_gnt", 32'(bus.aux_gnt), 32'(c == 21));
    end
    repeat (6) cyc(0, 0, 0, 0, 0);

    // Reset one cycle after an aux grant was issued
    cyc(1, 0, 0, 1, 17'h4000);
    chk("rst.gnt0", 32'(bus.aux_gnt), 0);
    cyc(1, 0, 0, 1, 17'h4000);
    chk("rst.gnt1", 32'(bus.aux_gnt), 1);
    cyc(0, 0, 0, 0, 0);
    chk("rst.mem_oe", 32'(bus.mem_oe), 1);
    chk("rst.mem_addr", 32'(bus.mem_addr), 32'h4000);
    reset = 1'b1;
    #1 chk_zero("rst_mid");
    cyc(1, 0, 0, 1, 17'h4000);
    chk_zero("rst_hold");
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      cyc(0, 0, 0, 0, 0);
      chk("rst.aux_valid", 32'(bus.aux_valid), 0);
      chk("rst.vga_valid", 32'(bus.vga_valid), 0);
    end
    chk("rst.state", 32'(dut.state_q), 32'(WAIT_BLANK));

    // Alternating VGA/aux in an open window, blank falls with aux in flight
    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].b, tbl[i].vr, tbl[i].va, tbl[i].ar, tbl[i].aa);
      chk($sformatf("alt[%0d].aux_gnt", i),   32'(bus.aux_gnt),   32'(tbl[i].g));
      chk($sformatf("alt[%0d].mem_oe", i),    32'(bus.mem_oe),    32'(tbl[i].oe));
      chk($sformatf("alt[%0d].mem_addr", i),  32'(bus.mem_addr),  32'(tbl[i].ma));
      chk($sformatf("alt[%0d].vga_valid", i), 32'(bus.vga_valid), 32'(tbl[i].vv));
      chk($sformatf("alt[%0d].vga_data", i),  32'(bus.vga_data),  32'(tbl[i].vd));
      chk($sformatf("alt[%0d].aux_valid", i), 32'(bus.aux_valid), 32'(tbl[i].av));
      chk($sformatf("alt[%0d].aux_data", i),  32'(bus.aux_data),  32'(tbl[i].ad));
      chk($sformatf("alt[%0d].overlap", i),   32'(bus.vga_valid & bus.aux_valid), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
